// File: rtl/operand_load_ctrl.sv
// Operand transfer sequencer: MAR->mem->MBR->BR reads, ACC->MBR->mem writes; read 4 cycles, write 3 cycles
// after acceptance, +1 per wait state, abort after TIMEOUT idle waits; one request at a time, req ignored while busy.
module operand_load_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mar_addr,
  output logic [15:0]       control_signals
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_MAR  = 3'd1,
    RD_WAIT = 3'd2,
    LD_BR   = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic              err_flag;
  logic              we_q;
  logic [ADDR_W-1:0] mar_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      err_flag <= 1'b0;
      we_q     <= 1'b0;
      mar_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            mar_q    <= addr;
            we_q     <= we;
            err_flag <= 1'b0;
            state    <= LD_MAR;
          end
        end
        LD_MAR: begin
          wait_cnt <= 8'd0;
          state    <= we_q ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT, WR_WAIT: begin
          // ready takes priority over a timeout landing in the same cycle
          if (mem_ready) begin
            state <= (state == RD_WAIT) ? LD_BR : DONE;
          end else if (wait_cnt == TO_LIM) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        LD_BR:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    control_signals = 16'h0000;
    case (state)
      LD_MAR: begin
        control_signals[3] = 1'b1;
        control_signals[9] = we_q;
      end
      RD_WAIT: begin
        control_signals[5] = 1'b1;
        control_signals[6] = mem_ready;
      end
      LD_BR:   control_signals[8] = 1'b1;
      WR_WAIT: control_signals[7] = 1'b1;
      default: control_signals = 16'h0000;
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_flag;
  assign mar_addr = mar_q;

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Directed bench for operand_load_ctrl with TIMEOUT=4.
module tb_operand_load_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic        mem_ready = 1'b0;
  logic        busy, done, err;
  logic [7:0]  mar_addr;
  logic [15:0] control_signals;

  int checks = 0;
  int errors = 0;

  operand_load_ctrl #(.TIMEOUT(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
    .mar_addr(mar_addr), .control_signals(control_signals)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to the next cycle, drive that cycle's inputs, settle
  task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic mr);
    @(posedge clk);
    #1;
    req = r; we = w; addr = a; mem_ready = mr;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic b, input logic d, input logic e,
                         input logic [15:0] c);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_ctrl"}, 32'(control_signals), 32'(c));
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("reset_mar", 32'(mar_addr), 32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;

    // read with mem_ready tied high
    cyc(1'b1, 1'b0, 8'h2A, 1'b1);
    chk_out("rd_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("rd_c1", 1'b1, 1'b0, 1'b0, 16'h0008);
    chk("rd_mar", 32'(mar_addr), 32'h2A);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("rd_c2", 1'b1, 1'b0, 1'b0, 16'h0060);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("rd_c3", 1'b1, 1'b0, 1'b0, 16'h0100);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("rd_c4", 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("rd_c5", 1'b0, 1'b0, 1'b0, 16'h0000);

    // write, ready after 3 wait cycles
    cyc(1'b1, 1'b1, 8'h10, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("wr_c1", 1'b1, 1'b0, 1'b0, 16'h0208);
    chk("wr_mar", 32'(mar_addr), 32'h10);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_out($sformatf("wr_c%0d", i), 1'b1, 1'b0, 1'b0, 16'h0080);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("wr_c5", 1'b1, 1'b0, 1'b0, 16'h0080);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("wr_c6", 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("wr_c7", 1'b0, 1'b0, 1'b0, 16'h0000);

    // read timeout: ready held low
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("to_c1", 1'b1, 1'b0, 1'b0, 16'h0008);
    for (int i = 2; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_out($sformatf("to_c%0d", i), 1'b1, 1'b0, 1'b0, 16'h0020);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("to_c7", 1'b1, 1'b1, 1'b1, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("to_c8", 1'b0, 1'b0, 1'b0, 16'h0000);

    // boundary: ready rises exactly as counter reaches TIMEOUT
    cyc(1'b1, 1'b0, 8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("bd_c1", 1'b1, 1'b0, 1'b0, 16'h0008);
    for (int i = 2; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk_out($sformatf("bd_c%0d", i), 1'b1, 1'b0, 1'b0, 16'h0020);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk_out("bd_c6", 1'b1, 1'b0, 1'b0, 16'h0060);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("bd_c7", 1'b1, 1'b0, 1'b0, 16'h0100);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("bd_c8", 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // req during an active read is ignored
    cyc(1'b1, 1'b0, 8'h33, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    chk("ign_ctrl", 32'(control_signals), 32'h0020);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ign_mar", 32'(mar_addr), 32'h33);
    chk("ign_ctrl2", 32'(control_signals), 32'h0020);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_out("ign_done", 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ign_idle", 32'(busy), 32'h0);

    // reset mid RD_WAIT
    cyc(1'b1, 1'b0, 8'h44, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mr_pre_ctrl", 32'(control_signals), 32'h0020);
    #2 rst = 1'b1;
    #1;
    chk_out("mr_rst", 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("mr_mar", 32'(mar_addr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk_out($sformatf("mr_post%0d", i), 1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // back-to-back reads with req held: done every 5 cycles
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 8'h2A, 1'b1);
      chk($sformatf("b2b_done%0d", i), 32'(done), 32'((i % 5) == 4));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
